sarray_row_feeder: RTL and testbench
====================================

# sarray_row_feeder

Left-edge stream transmitter for one row of the systolic array. Accepts a command (preload C or stream A) plus a word stream from the operand buffer. Drives the PE left-input protocol (valid, cnt, type, precision, data) into column 0 of its row, with a per-row skew delay. One instance per row; the controller aligns A beats with the top-edge B beats.

## Interface
- `ROW`, default 0: row index y; output skew in cycles (0..`SARRAY_H-1`).
- `W`, default `SARRAY_W`: array width, i.e. the number of C words per preload.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when both valid and ready are high.
- `cmd_op_i` in 1: 0 = stream A (`PE_DATA_TYPE_A`), 1 = preload C (`PE_DATA_TYPE_C`).
- `cmd_precision_i` in `TMMA_PRECISION_WIDTH`: precision tag carried on every A beat.
- `cmd_len_i` in `TMMA_CNT_WIDTH`: number of A beats; ignored for C.
- `src_valid_i` in 1: source word valid.
- `src_ready_o` out 1: source word consumed when both valid and ready are high.
- `src_data_i` in `PE_INPUT_DATA_WIDTH`: source word.
- `left_data_valid_o` out 1: to PE(ROW,0) `left_data_valid_i`.
- `left_data_cnt_o` out `TMMA_CNT_WIDTH`: beat tag.
- `left_data_type_o` out 1: A/C type.
- `left_precision_o` out `TMMA_PRECISION_WIDTH`: precision tag.
- `left_data_o` out `PE_INPUT_DATA_WIDTH`: data.
- `busy_o` out 1: a command is active or the skew pipe holds a valid beat.

## Operation
- **FSM states:** IDLE, LOADC, STREAMA.
- **cmd_ready_o:** equals (state == IDLE).
- **src_ready_o:** equals (state != IDLE). Nothing in this block can stall it.
- **IDLE, command accepted:**
  - Latch op, precision, and len; clear the beat counter k.
  - op=1 goes to LOADC.
  - op=0 with len != 0 goes to STREAMA.
  - op=0 with len == 0 is consumed with no output; the FSM stays in IDLE.
- **LOADC:**
  - Each source handshake emits one beat: type C, cnt = k+1, precision = latched value, data = word.
  - k increments per beat.
  - After beat k = W-1, return to IDLE.
  - Column x captures cnt == W-x: the first word goes to the farthest column, and the last word (cnt=W) stays in column 0.
- **STREAMA:**
  - Each handshake emits: type A, cnt = k (0..len-1), latched precision, data = word.
  - After beat k = len-1, return to IDLE.
- **Source bubbles:** src_valid_i low produces a valid=0 slot. k does not advance and the slot is still shifted through the skew pipe, so beat spacing is preserved exactly.
- **Skew pipe:**
  - Beat fields are registered once, then pass through ROW further register stages.
  - ROW=0 gives a single register stage.
  - Valid and payload shift together every cycle. There is no back-pressure.
- **Payload when valid=0:** don't-care, but it must not toggle valid.
- **busy_o:** equals (state != IDLE) OR any valid bit set in the pipe.
- **Reset (async):**
  - FSM returns to IDLE, k clears, and all pipe valid bits clear.
  - All outputs are 0, except cmd_ready_o = 1.
  - An in-flight command is dropped with no partial drain.

## Timing
- A source handshake at cycle t appears on the left outputs at cycle t+1+ROW.
- cmd_ready_o goes high the cycle after the last beat's handshake. The earliest next command is accepted then.
- The first source handshake of a command is accepted the cycle after cmd acceptance. Cmd accept to first output beat is at minimum 2+ROW cycles.
- Back-to-back commands: the output gap between commands is exactly 1 cycle (the IDLE accept cycle), plus any source bubbles.
- Counter width: k never exceeds W or len-1. len = 2^`TMMA_CNT_WIDTH`-1 must stream fully without wrap.
- busy_o falls the cycle after the last valid beat leaves the final pipe stage.

## Test plan
- **Reset:** W=4, ROW=2, assert rst_n=0 mid-STREAMA with beats in the pipe → the next cycle has all outputs 0, cmd_ready_o=1, busy_o=0, and no stale beats after release.
- **C preload:** W=4, ROW=2, LOADC with words 0xA0..0xA3, src always valid → left outputs at cycles t+3..t+6 carry type C, cnt 1,2,3,4, data A0..A3; cmd_ready_o returns the cycle after the 4th handshake.
- **A stream:** len=5, precision=2, ROW=0, src valid every cycle → 5 beats 1 cycle after each handshake, type A, cnt 0..4, precision 2, contiguous valid.
- **Bubbles:** len=3, src_valid pattern 1,0,0,1,1 → output valid pattern 1,0,0,1,1 delayed by ROW+1, with cnt 0,1,2 on the valid slots.
- **Zero length and back-to-back:** len=0 A command → no output beat, cmd_ready_o stays 1. Then LOADC immediately followed by A len=2 → 4 C beats, a 1-cycle gap, then 2 A beats; busy_o is high throughout and low 1 cycle after the last output.
- **Counter boundary:** len = 2^`TMMA_CNT_WIDTH`-1 → the final beat cnt equals len-1, with exactly len valid beats.

Source files
------------

// File: rtl/sarray_row_feeder.sv
// ---------------------------------------------------------------------------
// sarray_row_feeder
//
// Left-edge stream transmitter for one row of the systolic array. It takes a
// command (preload C words or stream A beats) and a word stream from the
// operand buffer. It drives the PE left-input protocol into column 0 of its
// row. A per-row skew pipe of ROW extra stages delays every slot so that rows
// line up diagonally with the top-edge B beats.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_op_i              0 = stream A, 1 = preload C
//   cmd_precision_i       precision tag carried on every beat of the command
//   cmd_len_i             number of A beats (ignored for C, which uses W)
//   src_valid_i/ready_o   source word handshake (ready while a command runs)
//   src_data_i            source word
//   left_data_valid_o     beat valid into PE(ROW,0)
//   left_data_cnt_o       beat tag (C: 1..W, A: 0..len-1)
//   left_data_type_o      A/C type
//   left_precision_o      precision tag
//   left_data_o           beat data
//   busy_o                command active or a valid beat still in the pipe
// ---------------------------------------------------------------------------
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef SARRAY_H
`define SARRAY_H 4
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 4
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 8
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif

module sarray_row_feeder #(
  parameter int ROW = 0,
  parameter int W   = `SARRAY_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_op_i,
  input  logic [`TMMA_PRECISION_WIDTH-1:0] cmd_precision_i,
  input  logic [`TMMA_CNT_WIDTH-1:0]       cmd_len_i,
  input  logic                             src_valid_i,
  output logic                             src_ready_o,
  input  logic [`PE_INPUT_DATA_WIDTH-1:0]  src_data_i,
  output logic                             left_data_valid_o,
  output logic [`TMMA_CNT_WIDTH-1:0]       left_data_cnt_o,
  output logic                             left_data_type_o,
  output logic [`TMMA_PRECISION_WIDTH-1:0] left_precision_o,
  output logic [`PE_INPUT_DATA_WIDTH-1:0]  left_data_o,
  output logic                             busy_o
);

  localparam int CW = `TMMA_CNT_WIDTH;
  localparam int PW = `TMMA_PRECISION_WIDTH;
  localparam int DW = `PE_INPUT_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADC   = 2'd1,
    STREAMA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] len_q;
  logic [PW-1:0] prec_q;
  logic          cmd_fire, src_fire;

  logic          beat_type;
  logic [CW-1:0] beat_cnt;

  // Skew pipe: stage 0 is the first register, stage ROW drives the outputs.
  logic [ROW:0]  pv_q;
  logic [CW-1:0] pcnt_q  [ROW:0];
  logic          ptype_q [ROW:0];
  logic [PW-1:0] pprec_q [ROW:0];
  logic [DW-1:0] pdata_q [ROW:0];

  assign cmd_ready_o = (state_q == IDLE);
  assign src_ready_o = (state_q != IDLE);
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign src_fire    = src_valid_i & src_ready_o;

  // FSM state and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Command fields held for the lifetime of the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      prec_q <= '0;
    end else if (cmd_fire) begin
      len_q  <= cmd_len_i;
      prec_q <= cmd_precision_i;
    end
  end

  // Next-state logic. The counter is cleared on the final beat so that it
  // never reaches W or len, which keeps a maximum-length stream from
  // wrapping the counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          k_d = '0;
          if (cmd_op_i)
            state_d = LOADC;
          else if (cmd_len_i != '0)
            state_d = STREAMA;
        end
      end
      LOADC: begin
        if (src_fire) begin
          if (k_q == CW'(W - 1)) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      STREAMA: begin
        if (src_fire) begin
          if (k_q == len_q - CW'(1)) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // C beats are tagged 1..W so that column x latches tag W-x. A beats are
  // tagged 0..len-1.
  always_comb begin
    beat_type = `PE_DATA_TYPE_A;
    beat_cnt  = k_q;
    if (state_q == LOADC) begin
      beat_type = `PE_DATA_TYPE_C;
      beat_cnt  = k_q + CW'(1);
    end
  end

  // Every cycle shifts a slot, including bubbles, so beat spacing on the
  // output matches source spacing exactly. Payload follows valid blindly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i <= ROW; i++) begin
        pcnt_q[i]  <= '0;
        ptype_q[i] <= 1'b0;
        pprec_q[i] <= '0;
        pdata_q[i] <= '0;
      end
    end else begin
      pv_q[0]    <= src_fire;
      pcnt_q[0]  <= beat_cnt;
      ptype_q[0] <= beat_type;
      pprec_q[0] <= prec_q;
      pdata_q[0] <= src_data_i;
      for (int i = 1; i <= ROW; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pcnt_q[i]  <= pcnt_q[i-1];
        ptype_q[i] <= ptype_q[i-1];
        pprec_q[i] <= pprec_q[i-1];
        pdata_q[i] <= pdata_q[i-1];
      end
    end
  end

  assign left_data_valid_o = pv_q[ROW];
  assign left_data_cnt_o   = pcnt_q[ROW];
  assign left_data_type_o  = ptype_q[ROW];
  assign left_precision_o  = pprec_q[ROW];
  assign left_data_o       = pdata_q[ROW];
  assign busy_o            = (state_q != IDLE) | (|pv_q);

endmodule

// File: tb/tb_sarray_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_sarray_row_feeder
//
// Drives two feeder instances, ROW=0 and ROW=2 with W=4, from the same
// command and source stimulus. Each source beat pushes its expected output
// beat, including the cycle it must appear on, into a per-instance queue.
// A monitor on the falling clock edge pops and compares whenever an instance
// presents a valid beat.
// ---------------------------------------------------------------------------
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 4
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 3
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 8
`endif

module tb_sarray_row_feeder;

  localparam int CW = `TMMA_CNT_WIDTH;
  localparam int PW = `TMMA_PRECISION_WIDTH;
  localparam int DW = `PE_INPUT_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [PW-1:0] cmd_prec = '0;
  logic [CW-1:0] cmd_len = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;

  logic          r0_cmd_ready, r0_src_ready, r0_valid, r0_type, r0_busy;
  logic [CW-1:0] r0_cnt;
  logic [PW-1:0] r0_prec;
  logic [DW-1:0] r0_data;
  logic          r2_cmd_ready, r2_src_ready, r2_valid, r2_type, r2_busy;
  logic [CW-1:0] r2_cnt;
  logic [PW-1:0] r2_prec;
  logic [DW-1:0] r2_data;

  sarray_row_feeder #(.ROW(0), .W(4)) u_row0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(r0_cmd_ready), .cmd_op_i(cmd_op),
    .cmd_precision_i(cmd_prec), .cmd_len_i(cmd_len),
    .src_valid_i(src_valid), .src_ready_o(r0_src_ready), .src_data_i(src_data),
    .left_data_valid_o(r0_valid), .left_data_cnt_o(r0_cnt),
    .left_data_type_o(r0_type), .left_precision_o(r0_prec),
    .left_data_o(r0_data), .busy_o(r0_busy)
  );

  sarray_row_feeder #(.ROW(2), .W(4)) u_row2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(r2_cmd_ready), .cmd_op_i(cmd_op),
    .cmd_precision_i(cmd_prec), .cmd_len_i(cmd_len),
    .src_valid_i(src_valid), .src_ready_o(r2_src_ready), .src_data_i(src_data),
    .left_data_valid_o(r2_valid), .left_data_cnt_o(r2_cnt),
    .left_data_type_o(r2_type), .left_precision_o(r2_prec),
    .left_data_o(r2_data), .busy_o(r2_busy)
  );

  typedef struct {
    logic [CW-1:0] cnt;
    logic          typ;
    logic [PW-1:0] prec;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  beat_t q0[$];
  beat_t q2[$];
  beat_t e0, e2;

  logic          cur_type = 1'b0;
  logic [PW-1:0] cur_prec = '0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_beat(input string name, input beat_t e,
                              input logic [CW-1:0] cnt, input logic typ,
                              input logic [PW-1:0] prec, input logic [DW-1:0] data);
    n_checks++;
    if (cnt !== e.cnt || typ !== e.typ || prec !== e.prec ||
        data !== e.data || cyc != e.cyc) begin
      n_fails++;
      $display("[TB] FAIL %s beat: got cyc=%0d cnt=%0d type=%0d prec=%0d data=0x%0h, expected cyc=%0d cnt=%0d type=%0d prec=%0d data=0x%0h",
               name, cyc, cnt, typ, prec, data, e.cyc, e.cnt, e.typ, e.prec, e.data);
    end
  endtask

  // Monitor: every valid output beat must match the head of its queue.
  always @(negedge clk) begin
    if (r0_valid) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL row0 unexpected beat: got cyc=%0d cnt=%0d, expected no beat", cyc, r0_cnt);
      end else begin
        e0 = q0.pop_front();
        compare_beat("row0", e0, r0_cnt, r0_type, r0_prec, r0_data);
      end
    end
    if (r2_valid) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL row2 unexpected beat: got cyc=%0d cnt=%0d, expected no beat", cyc, r2_cnt);
      end else begin
        e2 = q2.pop_front();
        compare_beat("row2", e2, r2_cnt, r2_type, r2_prec, r2_data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic op, input logic [PW-1:0] prec,
                           input logic [CW-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_prec  = prec;
    cmd_len   = len;
    checkOutput("cmd_ready_at_accept", {31'd0, r0_cmd_ready}, 32'd1);
    cur_type  = op;
    cur_prec  = prec;
    step(1);
    cmd_valid = 1'b0;
  endtask

  // One source slot; a valid slot pushes its expected beat for both rows.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic [CW-1:0] exp_cnt);
    beat_t b;
    src_valid = v;
    src_data  = d;
    checkOutput("src_ready_active", {31'd0, r0_src_ready}, 32'd1);
    checkOutput("busy_active", {30'd0, r0_busy, r2_busy}, 32'd3);
    if (v) begin
      b.cnt  = exp_cnt;
      b.typ  = cur_type;
      b.prec = cur_prec;
      b.data = d;
      b.cyc  = cyc + 1;
      q0.push_back(b);
      b.cyc  = cyc + 3;
      q2.push_back(b);
    end
    step(1);
    src_valid = 1'b0;
    src_data  = '0;
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_valid", {30'd0, r0_valid, r2_valid}, 32'd0);
    checkOutput("rst_cnt", {r0_cnt, r2_cnt}, 32'd0);
    checkOutput("rst_type", {30'd0, r0_type, r2_type}, 32'd0);
    checkOutput("rst_prec", {r0_prec, r2_prec}, 32'd0);
    checkOutput("rst_data", {r0_data, r2_data}, 32'd0);
    checkOutput("rst_cmd_ready", {30'd0, r0_cmd_ready, r2_cmd_ready}, 32'd3);
    checkOutput("rst_src_ready", {30'd0, r0_src_ready, r2_src_ready}, 32'd0);
    checkOutput("rst_busy", {30'd0, r0_busy, r2_busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    step(2);
    rst_n = 1'b1;
    step(1);
    checkOutput("idle_cmd_ready", {31'd0, r0_cmd_ready}, 32'd1);

    // C preload: tags 1..4, cmd_ready returns right after the 4th word.
    $display("[TB] C preload");
    issue_cmd(1'b1, 3'd5, 4'd0);
    checkOutput("cmd_ready_low_loadc", {30'd0, r0_cmd_ready, r2_cmd_ready}, 32'd0);
    applyStimulus(1'b1, 8'hA0, 4'd1);
    applyStimulus(1'b1, 8'hA1, 4'd2);
    applyStimulus(1'b1, 8'hA2, 4'd3);
    applyStimulus(1'b1, 8'hA3, 4'd4);
    checkOutput("cmd_ready_after_loadc", {30'd0, r0_cmd_ready, r2_cmd_ready}, 32'd3);
    step(6);
    checkOutput("busy_after_loadc", {30'd0, r0_busy, r2_busy}, 32'd0);

    // A stream, len=5, precision=2.
    $display("[TB] A stream");
    issue_cmd(1'b0, 3'd2, 4'd5);
    applyStimulus(1'b1, 8'h10, 4'd0);
    applyStimulus(1'b1, 8'h11, 4'd1);
    applyStimulus(1'b1, 8'h12, 4'd2);
    applyStimulus(1'b1, 8'h13, 4'd3);
    applyStimulus(1'b1, 8'h14, 4'd4);
    checkOutput("cmd_ready_after_a", {31'd0, r0_cmd_ready}, 32'd1);
    step(6);

    // Source bubbles: pattern 1,0,0,1,1.
    $display("[TB] bubbles");
    issue_cmd(1'b0, 3'd1, 4'd3);
    applyStimulus(1'b1, 8'h21, 4'd0);
    applyStimulus(1'b0, 8'hEE, 4'd0);
    applyStimulus(1'b0, 8'hEE, 4'd0);
    applyStimulus(1'b1, 8'h22, 4'd1);
    applyStimulus(1'b1, 8'h23, 4'd2);
    checkOutput("cmd_ready_after_bubbles", {31'd0, r0_cmd_ready}, 32'd1);
    step(6);

    // Zero-length A command: swallowed, nothing emitted.
    $display("[TB] zero length");
    issue_cmd(1'b0, 3'd3, 4'd0);
    checkOutput("zero_len_cmd_ready", {30'd0, r0_cmd_ready, r2_cmd_ready}, 32'd3);
    checkOutput("zero_len_busy", {30'd0, r0_busy, r2_busy}, 32'd0);
    step(5);

    // Back-to-back: 4 C beats, one idle slot, then 2 A beats.
    $display("[TB] back to back");
    issue_cmd(1'b1, 3'd4, 4'd0);
    applyStimulus(1'b1, 8'hB0, 4'd1);
    applyStimulus(1'b1, 8'hB1, 4'd2);
    applyStimulus(1'b1, 8'hB2, 4'd3);
    applyStimulus(1'b1, 8'hB3, 4'd4);
    checkOutput("b2b_gap_busy", {30'd0, r0_busy, r2_busy}, 32'd3);
    issue_cmd(1'b0, 3'd6, 4'd2);
    applyStimulus(1'b1, 8'hC0, 4'd0);
    applyStimulus(1'b1, 8'hC1, 4'd1);
    checkOutput("b2b_busy_last_out_row0", {30'd0, r0_busy, r2_busy}, 32'd3);
    step(1);
    checkOutput("b2b_busy_drop_row0", {30'd0, r0_busy, r2_busy}, 32'd1);
    step(1);
    checkOutput("b2b_busy_last_out_row2", {31'd0, r2_busy}, 32'd1);
    step(1);
    checkOutput("b2b_busy_drop_row2", {31'd0, r2_busy}, 32'd0);
    step(2);

    // Counter boundary: maximum length streams fully without wrapping.
    $display("[TB] counter boundary");
    issue_cmd(1'b0, 3'd7, 4'd15);
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, DW'(8'h40 + i), CW'(i));
    checkOutput("cmd_ready_after_max", {31'd0, r0_cmd_ready}, 32'd1);
    step(6);
    checkOutput("max_len_drained", q0.size() + q2.size(), 32'd0);

    // Reset in the middle of a stream with beats in the pipe.
    $display("[TB] reset mid-stream");
    issue_cmd(1'b0, 3'd3, 4'd5);
    applyStimulus(1'b1, 8'h51, 4'd0);
    applyStimulus(1'b1, 8'h52, 4'd1);
    applyStimulus(1'b1, 8'h53, 4'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q0.delete();
    q2.delete();
    step(2);
    rst_n = 1'b1;
    step(8);
    check_reset_outputs();

    checkOutput("row0_queue_empty", q0.size(), 32'd0);
    checkOutput("row2_queue_empty", q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
